// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: result source select and load funct3 codes.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_NONE = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension; flags misaligned or unknown loads.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data,
  output logic        fault
);

  logic [31:0] shifted;

  // Shift the addressed byte down to bit 0, then extend according to load type.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = '0;
    fault   = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU: data = {24'b0, shifted[7:0]};
      F3_LH: begin
        data  = {{16{shifted[15]}}, shifted[15:0]};
        fault = off[0];
      end
      F3_LHU: begin
        data  = {16'b0, shifted[15:0]};
        fault = off[0];
      end
      F3_LW: begin
        data  = rdata;
        fault = (off != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registers Memory-stage results, waits for late load data,
// drives the GPR write port and counts retired instructions.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 M_valid,
  input  logic [4:0]           M_rd_addr,
  input  logic [XLEN-1:0]      M_alu_result,
  input  logic [XLEN-1:0]      M_pc_plus4,
  input  logic [1:0]           M_result_src,
  input  logic [2:0]           M_funct3,
  input  logic                 M_gpr_wen,
  output logic                 M_stall,
  input  logic                 dmem_rvalid,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [4:0]           W_rd_addr,
  output logic [XLEN-1:0]      W_rd,
  output logic                 W_gpr_wen,
  output logic                 W_retire,
  output logic                 W_load_fault,
  output logic [INSTRET_W-1:0] W_instret
);

  typedef enum logic [0:0] {WB_IDLE, WB_WAIT_LOAD} wb_state_e;

  wb_state_e state_q, state_d;

  // Fields of a load parked while waiting for its data
  logic [4:0] ld_rd_q, ld_rd_d;
  logic [2:0] ld_f3_q, ld_f3_d;
  logic [1:0] ld_off_q, ld_off_d;
  logic       ld_wen_q, ld_wen_d;

  logic [4:0]           w_rd_addr_q;
  logic [XLEN-1:0]      w_rd_q;
  logic                 w_gpr_wen_q, w_retire_q, w_load_fault_q;
  logic [INSTRET_W-1:0] instret_q;

  logic            cap;
  result_src_e     cap_src;
  logic [4:0]      cap_rd;
  logic            cap_wen;
  logic [2:0]      ext_f3;
  logic [1:0]      ext_off;
  logic [31:0]     ext_data;
  logic            ext_fault;
  logic            fault;
  logic            wen_d;
  logic [XLEN-1:0] result;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .funct3 (ext_f3),
    .off    (ext_off),
    .data   (ext_data),
    .fault  (ext_fault)
  );

  // Next-state, stall and capture decode; WAIT_LOAD uses only the parked fields.
  always_comb begin
    state_d  = state_q;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    ld_wen_d = ld_wen_q;
    M_stall  = 1'b0;
    cap      = 1'b0;
    cap_src  = result_src_e'(M_result_src);
    cap_rd   = M_rd_addr;
    cap_wen  = M_gpr_wen;
    ext_f3   = M_funct3;
    ext_off  = M_alu_result[1:0];
    case (state_q)
      WB_IDLE: begin
        if (M_valid) begin
          if (cap_src == RES_LOAD && !dmem_rvalid) begin
            M_stall  = 1'b1;
            state_d  = WB_WAIT_LOAD;
            ld_rd_d  = M_rd_addr;
            ld_f3_d  = M_funct3;
            ld_off_d = M_alu_result[1:0];
            ld_wen_d = M_gpr_wen;
          end else begin
            cap = 1'b1;
          end
        end
      end
      WB_WAIT_LOAD: begin
        cap_src = RES_LOAD;
        cap_rd  = ld_rd_q;
        cap_wen = ld_wen_q;
        ext_f3  = ld_f3_q;
        ext_off = ld_off_q;
        M_stall = !dmem_rvalid;
        if (dmem_rvalid) begin
          cap     = 1'b1;
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase

    fault = (cap_src == RES_LOAD) && ext_fault;
    case (cap_src)
      RES_LOAD: result = ext_data;
      RES_PC4:  result = M_pc_plus4;
      default:  result = M_alu_result;
    endcase
    wen_d = cap && cap_wen && (cap_rd != 5'd0) && !fault && (cap_src != RES_NONE);
  end

  // State, parked load fields and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WB_IDLE;
      ld_rd_q        <= '0;
      ld_f3_q        <= '0;
      ld_off_q       <= '0;
      ld_wen_q       <= 1'b0;
      w_rd_addr_q    <= '0;
      w_rd_q         <= '0;
      w_gpr_wen_q    <= 1'b0;
      w_retire_q     <= 1'b0;
      w_load_fault_q <= 1'b0;
      instret_q      <= '0;
    end else begin
      state_q        <= state_d;
      ld_rd_q        <= ld_rd_d;
      ld_f3_q        <= ld_f3_d;
      ld_off_q       <= ld_off_d;
      ld_wen_q       <= ld_wen_d;
      w_gpr_wen_q    <= wen_d;
      w_retire_q     <= cap;
      w_load_fault_q <= cap && fault;
      instret_q      <= instret_q + INSTRET_W'(cap);
      if (cap) begin
        w_rd_addr_q <= cap_rd;
        w_rd_q      <= result;
      end
    end
  end

  assign W_rd_addr    = w_rd_addr_q;
  assign W_rd         = w_rd_q;
  assign W_gpr_wen    = w_gpr_wen_q;
  assign W_retire     = w_retire_q;
  assign W_load_fault = w_load_fault_q;
  assign W_instret    = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic against a
// transaction-level model. A second instance with a 4-bit counter checks wrap.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_valid;
  logic [4:0]  M_rd_addr;
  logic [31:0] M_alu_result, M_pc_plus4;
  logic [1:0]  M_result_src;
  logic [2:0]  M_funct3;
  logic        M_gpr_wen;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        M_stall, W_gpr_wen, W_retire, W_load_fault;
  logic [4:0]  W_rd_addr;
  logic [31:0] W_rd;
  logic [63:0] W_instret;

  logic        s_stall, s_gpr_wen, s_retire, s_load_fault;
  logic [4:0]  s_rd_addr;
  logic [31:0] s_rd;
  logic [3:0]  s_instret;

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;

  // Reference model state
  bit          pend;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  int unsigned p_off;
  bit          p_gw;
  bit          e_wen, e_retire, e_fault, e_known;
  logic [4:0]  e_addr;
  logic [31:0] e_rd;
  logic [63:0] e_instret;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk(clk), .reset(reset), .M_valid(M_valid), .M_rd_addr(M_rd_addr),
    .M_alu_result(M_alu_result), .M_pc_plus4(M_pc_plus4), .M_result_src(M_result_src),
    .M_funct3(M_funct3), .M_gpr_wen(M_gpr_wen), .M_stall(M_stall),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .W_rd_addr(W_rd_addr),
    .W_rd(W_rd), .W_gpr_wen(W_gpr_wen), .W_retire(W_retire),
    .W_load_fault(W_load_fault), .W_instret(W_instret)
  );

  writeback_unit #(.XLEN(32), .INSTRET_W(4)) dut_small (
    .clk(clk), .reset(reset), .M_valid(M_valid), .M_rd_addr(M_rd_addr),
    .M_alu_result(M_alu_result), .M_pc_plus4(M_pc_plus4), .M_result_src(M_result_src),
    .M_funct3(M_funct3), .M_gpr_wen(M_gpr_wen), .M_stall(s_stall),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .W_rd_addr(s_rd_addr),
    .W_rd(s_rd), .W_gpr_wen(s_gpr_wen), .W_retire(s_retire),
    .W_load_fault(s_load_fault), .W_instret(s_instret)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load semantics from first principles: pick the addressed bytes, extend arithmetically.
  function automatic void model_load(input logic [31:0] word, input logic [2:0] f3,
                                     input int unsigned off, output logic [31:0] val,
                                     output bit flt);
    longint unsigned w = 64'(word);
    longint unsigned b = (w >> (8 * off)) % 256;
    longint unsigned h = (w >> (8 * off)) % 65536;
    flt = 0;
    val = 0;
    case (f3)
      3'd0: val = 32'((b >= 128) ? b + 64'hFFFF_FF00 : b);
      3'd4: val = 32'(b);
      3'd1: begin val = 32'((h >= 32768) ? h + 64'hFFFF_0000 : h); flt = (off % 2) != 0; end
      3'd5: begin val = 32'(h); flt = (off % 2) != 0; end
      3'd2: begin val = word; flt = off != 0; end
      default: flt = 1;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check_value({tag, ".wen"}, 64'(W_gpr_wen), 64'(e_wen));
    check_value({tag, ".retire"}, 64'(W_retire), 64'(e_retire));
    check_value({tag, ".fault"}, 64'(W_load_fault), 64'(e_fault));
    check_value({tag, ".instret"}, W_instret, e_instret);
    check_value({tag, ".instret4"}, 64'(s_instret), 64'(e_instret[3:0]));
    if (e_known) begin
      check_value({tag, ".rd_addr"}, 64'(W_rd_addr), 64'(e_addr));
      check_value({tag, ".rd"}, 64'(W_rd), 64'(e_rd));
    end
  endtask

  task automatic model_retire(input logic [4:0] rd, input bit gw, input logic [1:0] src,
                              input logic [31:0] val, input bit flt);
    e_retire = 1;
    e_fault  = flt;
    e_wen    = gw && rd != 0 && !flt && src != 2'b11;
    e_instret = e_instret + 64'd1;
    if (e_wen) begin
      e_known = 1;
      e_addr  = rd;
      e_rd    = val;
    end else begin
      e_known = 0;
    end
  endtask

  // One clock cycle: drive, check stall mid-cycle, clock, check registered outputs.
  task automatic step(input string tag, input bit v, input logic [1:0] src,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                      input logic [2:0] f3, input bit gw, input bit rv, input logic [31:0] rdata);
    logic [31:0] val;
    bit flt, exp_stall;
    M_valid = v; M_result_src = src; M_rd_addr = rd; M_alu_result = alu;
    M_pc_plus4 = pc4; M_funct3 = f3; M_gpr_wen = gw; dmem_rvalid = rv; dmem_rdata = rdata;
    #1;
    exp_stall = (pend && !rv) || (!pend && v && src == 2'b01 && !rv);
    check_value({tag, ".stall"}, 64'(M_stall), 64'(exp_stall));
    if (M_stall) stall_seen++;
    @(posedge clk);
    #1;
    e_wen = 0; e_retire = 0; e_fault = 0;
    if (pend) begin
      if (rv) begin
        model_load(rdata, p_f3, p_off, val, flt);
        model_retire(p_rd, p_gw, 2'b01, val, flt);
        pend = 0;
      end
    end else if (v) begin
      if (src == 2'b01) begin
        if (rv) begin
          model_load(rdata, f3, alu % 4, val, flt);
          model_retire(rd, gw, src, val, flt);
        end else begin
          pend = 1; p_rd = rd; p_f3 = f3; p_off = alu % 4; p_gw = gw;
        end
      end else begin
        model_retire(rd, gw, src, (src == 2'b10) ? pc4 : alu, 0);
      end
    end
    check_outputs(tag);
  endtask

  task automatic bubble(input string tag, input bit rv);
    step(tag, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 0, rv, 32'hDEAD_BEEF);
  endtask

  task automatic do_reset(input string tag);
    reset = 1; M_valid = 0; dmem_rvalid = 0;
    @(posedge clk);
    #1;
    reset = 0;
    pend = 0; e_wen = 0; e_retire = 0; e_fault = 0; e_known = 1;
    e_addr = 0; e_rd = 0; e_instret = 0;
    check_value({tag, ".stall"}, 64'(M_stall), 64'd0);
    check_outputs(tag);
  endtask

  initial begin
    reset = 0; M_valid = 0; M_rd_addr = 0; M_alu_result = 0; M_pc_plus4 = 0;
    M_result_src = 0; M_funct3 = 0; M_gpr_wen = 0; dmem_rvalid = 0; dmem_rdata = 0;
    do_reset("reset");

    // ALU op and link value
    step("alu", 1, 2'b00, 5'd5, 32'h1234, 32'h0, 3'd0, 1, 0, 32'h0);
    check_value("alu.rd_direct", 64'(W_rd), 64'h1234);
    check_value("alu.instret_direct", W_instret, 64'd1);
    step("pc4", 1, 2'b10, 5'd7, 32'h1, 32'h0000_0104, 3'd0, 1, 0, 32'h0);
    bubble("hold", 0);
    check_value("hold.rd_direct", 64'(W_rd), 64'h0000_0104);

    // Load hits
    stall_seen = 0;
    step("lb_hit", 1, 2'b01, 5'd3, 32'h1000_0002, 32'h0, 3'd0, 1, 1, 32'h80FF_0000);
    check_value("lb_hit.rd_direct", 64'(W_rd), 64'hFFFF_FFFF);
    step("lbu_hit", 1, 2'b01, 5'd3, 32'h1000_0002, 32'h0, 3'd4, 1, 1, 32'h80FF_0000);
    check_value("lbu_hit.rd_direct", 64'(W_rd), 64'h0000_00FF);
    check_value("hit.no_stall", 64'(stall_seen), 64'd0);

    // Load miss: data arrives in the fourth cycle
    stall_seen = 0;
    step("lh_miss0", 1, 2'b01, 5'd9, 32'h2000_0002, 32'h0, 3'd1, 1, 0, 32'h0);
    step("lh_miss1", 1, 2'b00, 5'd1, 32'hFFFF_FFFF, 32'h0, 3'd7, 1, 0, 32'h0);
    step("lh_miss2", 0, 2'b00, 5'd1, 32'h0, 32'h0, 3'd0, 1, 0, 32'h0);
    step("lh_miss3", 1, 2'b00, 5'd2, 32'h3, 32'h0, 3'd2, 0, 1, 32'h8001_0000);
    check_value("lh_miss.rd_direct", 64'(W_rd), 64'hFFFF_8001);
    check_value("lh_miss.stall_cycles", 64'(stall_seen), 64'd3);

    // Faults
    step("lw_mis", 1, 2'b01, 5'd4, 32'h0000_0001, 32'h0, 3'd2, 1, 1, 32'h1234_5678);
    check_value("lw_mis.fault_direct", 64'(W_load_fault), 64'd1);
    step("f3_bad", 1, 2'b01, 5'd4, 32'h0000_0000, 32'h0, 3'd3, 1, 1, 32'h1234_5678);

    // x0 write suppressed, stray rvalid ignored, reserved source
    step("x0", 1, 2'b00, 5'd0, 32'h55, 32'h0, 3'd0, 1, 0, 32'h0);
    check_value("x0.wen_direct", 64'(W_gpr_wen), 64'd0);
    step("alu_w", 1, 2'b00, 5'd6, 32'hABCD, 32'h0, 3'd0, 1, 0, 32'h0);
    bubble("stray", 1);
    step("stray_alu", 1, 2'b00, 5'd8, 32'h77, 32'h0, 3'd0, 1, 1, 32'hFFFF_FFFF);
    step("res_none", 1, 2'b11, 5'd8, 32'h99, 32'h0, 3'd0, 1, 0, 32'h0);

    // Reset while waiting for load data; the late response must be dropped
    step("rst_wait0", 1, 2'b01, 5'd10, 32'h0, 32'h0, 3'd2, 1, 0, 32'h0);
    bubble("rst_wait1", 0);
    do_reset("rst_mid");
    bubble("late_rvalid", 1);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) step("wrap", 1, 2'b00, 5'd1, i, 32'h0, 3'd0, 1, 0, 32'h0);
    check_value("wrap.small", 64'(s_instret), 64'd0);
    check_value("wrap.full", W_instret, 64'd16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] src;
      src = 2'($urandom_range(0, 3));
      step("rand", $urandom_range(0, 3) != 0, src, 5'($urandom_range(0, 31)), $urandom,
           $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
